// File: rtl/opb_register_ppc2simulink.sv
// OPB slave exposing one 32-bit software-written control register to fabric logic,
// with a one-cycle update strobe. Define OPB_REG_P2S_READBACK_EN to make the register readable.
module opb_register_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0108C200,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108C2FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic [31:0] user_data_out,
    output logic        user_data_strb
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    // Widths are fixed at 32; the family string is informational only.
    localparam int unused_cfg = C_OPB_AWIDTH + C_OPB_DWIDTH + $bits(C_FAMILY);

    logic        unused_seq_s;
    logic [0:0]  state_r;
    logic        rnw_r;
    logic [3:0]  be_r;
    logic [31:0] dbus_r;
    logic [31:0] data_r;
    logic [31:0] rdata_r;
    logic        ack_r;
    logic        strb_r;
    logic        hit_s;
    logic [31:0] merged_s;

    // Byte j of the register takes byte j of the write data when its enable is set.
    // be/dbus are already in user bit order, so OPB lane k lands on byte 3-k.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int j = 0; j < 4; j++) begin
            if (be[j]) begin
                res[8*j +: 8] = wdat[8*j +: 8];
            end else begin
                res[8*j +: 8] = cur[8*j +: 8];
            end
        end
        return res;
    endfunction

    assign unused_seq_s = OPB_seqAddr;

    // Address decode: the whole window aliases the single register.
    always_comb begin
        hit_s = 1'b0;
        if (OPB_select && (state_r == IDLE) &&
            (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Merge of the latched write into the current register value.
    always_comb begin
        merged_s = merge_bytes(data_r, dbus_r, be_r);
    end

    // Transfer FSM: capture the request on a hit, spend one cycle in ACK.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_r <= IDLE;
            rnw_r   <= 1'b1;
            be_r    <= 4'b0000;
            dbus_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_s) begin
                        rnw_r   <= OPB_RNW;
                        be_r    <= OPB_BE;
                        dbus_r  <= OPB_DBus;
                        state_r <= ACK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACK:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Registered bus response, register update and strobe on leaving ACK.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            ack_r   <= 1'b0;
            strb_r  <= 1'b0;
            data_r  <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else if (state_r == ACK) begin
            ack_r  <= 1'b1;
            strb_r <= ~rnw_r;
            if (!rnw_r) begin
                data_r <= merged_s;
            end else begin
                data_r <= data_r;
            end
`ifdef OPB_REG_P2S_READBACK_EN
            rdata_r <= rnw_r ? data_r : 32'h0000_0000;
`else
            rdata_r <= 32'h0000_0000;
`endif
        end else begin
            ack_r   <= 1'b0;
            strb_r  <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end
    end

    // Plain assignment of [31:0] to [0:31] performs the bit reversal to OPB order.
    assign Sl_DBus        = rdata_r;
    assign Sl_xferAck     = ack_r;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_data_out  = data_r;
    assign user_data_strb = strb_r;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed self-checking bench for opb_register_ppc2simulink.
module tb_opb_register_ppc2simulink;

`ifdef OPB_REG_P2S_READBACK_EN
    localparam logic [31:0] RB_EXP = 32'hDE22BE44;
`else
    localparam logic [31:0] RB_EXP = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [0:31] sl_dbus;
    logic        sl_ack;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic [31:0] udata;
    logic        ustrb;

    int compared;
    int mismatched;

    opb_register_ppc2simulink dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (sl_ack),
        .Sl_errAck     (sl_err),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout),
        .user_data_out (udata),
        .user_data_strb(ustrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic r, input logic [3:0] b,
                         input logic [31:0] d);
        sel  = 1'b1;
        abus = a;
        rnw  = r;
        be   = b;
        dbus = d;
    endtask

    task automatic idle();
        sel  = 1'b0;
        abus = 32'h0;
        rnw  = 1'b0;
        be   = 4'b0000;
        dbus = 32'h0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b0;
        seq = 1'b0;
        idle();

        // Asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        check("rst_ack",  {31'b0, sl_ack}, 32'h0);
        check("rst_strb", {31'b0, ustrb}, 32'h0);
        check("rst_data", udata, 32'h0);
        check("rst_dbus", sl_dbus, 32'h0);
        check("rst_tied", {29'b0, sl_err, sl_retry, sl_tout}, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_data", udata, 32'h0);

        // Full write
        drive(32'h0108C200, 1'b0, 4'b1111, 32'hDEADBEEF);
        step();
        check("wr_ack_not_early", {31'b0, sl_ack}, 32'h0);
        idle();
        step();
        check("wr_ack",  {31'b0, sl_ack}, 32'h1);
        check("wr_strb", {31'b0, ustrb}, 32'h1);
        check("wr_data", udata, 32'hDEADBEEF);
        step();
        check("wr_ack_low",  {31'b0, sl_ack}, 32'h0);
        check("wr_strb_low", {31'b0, ustrb}, 32'h0);
        check("wr_data_hold", udata, 32'hDEADBEEF);

        // Byte-lane write
        drive(32'h0108C280, 1'b0, 4'b0101, 32'h11223344);
        step();
        idle();
        step();
        check("bl_ack",  {31'b0, sl_ack}, 32'h1);
        check("bl_data", udata, 32'hDE22BE44);
        step();

        // Write with no byte enables: acked and strobed, register unchanged
        drive(32'h0108C2FF, 1'b0, 4'b0000, 32'hFFFFFFFF);
        step();
        idle();
        step();
        check("be0_ack",  {31'b0, sl_ack}, 32'h1);
        check("be0_strb", {31'b0, ustrb}, 32'h1);
        check("be0_data", udata, 32'hDE22BE44);
        step();

        // Readback
        drive(32'h0108C2FC, 1'b1, 4'b1111, 32'h0);
        step();
        check("rd_dbus_before", sl_dbus, 32'h0);
        idle();
        step();
        check("rd_ack",  {31'b0, sl_ack}, 32'h1);
        check("rd_strb", {31'b0, ustrb}, 32'h0);
        check("rd_dbus", sl_dbus, RB_EXP);
        step();
        check("rd_dbus_after", sl_dbus, 32'h0);
        check("rd_ack_low", {31'b0, sl_ack}, 32'h0);

        // Address misses just above and below the window
        drive(32'h0108C300, 1'b0, 4'b1111, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("miss_hi_ack_strb", {31'b0, sl_ack | ustrb}, 32'h0);
        end
        drive(32'h0108C1FC, 1'b0, 4'b1111, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("miss_lo_ack_strb", {31'b0, sl_ack | ustrb}, 32'h0);
        end
        idle();
        check("miss_data", udata, 32'hDE22BE44);
        step();

        // Back-to-back writes with select held
        drive(32'h0108C200, 1'b0, 4'b1111, 32'h0000_0001);
        step();
        dbus = 32'h0000_0002;
        step();
        check("b2b_ack1",  {31'b0, sl_ack}, 32'h1);
        check("b2b_strb1", {31'b0, ustrb}, 32'h1);
        check("b2b_data1", udata, 32'h1);
        step();
        check("b2b_gap", {31'b0, sl_ack}, 32'h0);
        idle();
        step();
        check("b2b_ack2",  {31'b0, sl_ack}, 32'h1);
        check("b2b_strb2", {31'b0, ustrb}, 32'h1);
        check("b2b_data2", udata, 32'h2);
        step();
        check("b2b_end", {31'b0, sl_ack | ustrb}, 32'h0);

        // Reset asserted during the acknowledge cycle
        drive(32'h0108C200, 1'b0, 4'b1111, 32'hCAFEF00D);
        step();
        idle();
        step();
        check("mid_ack_pre", {31'b0, sl_ack}, 32'h1);
        check("mid_data_pre", udata, 32'hCAFEF00D);
        #2 rst = 1'b1;
        #1;
        check("mid_ack_drop", {31'b0, sl_ack}, 32'h0);
        check("mid_strb_drop", {31'b0, ustrb}, 32'h0);
        check("mid_data_clr", udata, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("mid_after_ack", {31'b0, sl_ack | ustrb}, 32'h0);
        check("mid_after_data", udata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/opb_register_ppc2simulink.md
# opb_register_ppc2simulink

OPB slave holding one 32-bit software-writable register whose contents drive a fabric (user) output, with a one-cycle update strobe. It is the PPC-to-fabric counterpart of the simulink2ppc status register. It sits on the same OPB segment as the status registers and gives the PowerPC control words such as FFT shift, accumulation length and arm/reset bits. Single clock domain: the user logic runs on OPB_Clk.

## Interface
- C_BASEADDR, 32'h0108C200, first byte address decoded.
- C_HIGHADDR, 32'h0108C2FF, last byte address decoded; the whole range aliases the one register.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
- C_FAMILY, "virtex5", target family; informational only.

Ports:
- OPB_Clk  in  1  the only clock.
- OPB_Rst  in  1  reset: asynchronous, active-high.
- OPB_ABus  in  [0:31]  address; bit 0 is the MSB.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  master transfer valid.
- OPB_seqAddr  in  1  sequential-burst hint; ignored.
- Sl_DBus  out  [0:31]  read data; all-zero when not acking a read.
- Sl_xferAck  out  1  transfer acknowledge, one-cycle pulse.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0.
- user_data_out  out  [31:0]  register contents; user bit 31 = OPB bit 0.
- user_data_strb  out  1  one-cycle pulse on every accepted write.

## Operation
- Hit condition: OPB_select=1, and C_BASEADDR <= OPB_ABus <= C_HIGHADDR (unsigned compare), and the FSM is in IDLE.
- FSM state IDLE: on a hit at edge N, latch OPB_RNW, OPB_BE and OPB_DBus, then go to ACK. Otherwise stay in IDLE.
- FSM state ACK: Sl_xferAck=1 for exactly this cycle, then go unconditionally to IDLE.
- Back-to-back transfers: if OPB_select is still high in IDLE at edge N+2, that is a new transfer. The maximum rate is therefore one transfer every 2 cycles.
- Write, byte-lane merge: for each lane k in 0..3, if BE[k]=1 then register byte (3-k) takes DBus[8k:8k+7]. Unselected bytes hold their value.
- A write with BE=4'b0000 is still acked and still strobes; the register is unchanged.
- Read: Sl_DBus carries the register contents, bit-reversed to OPB order, during the ACK cycle only. It is zero in every other cycle because the bus is wired-OR.
- Read-modify-write is not required: the register is the sole storage.
- Reset values: register = 0, user_data_out = 0, user_data_strb = 0, Sl_xferAck = 0, Sl_DBus = 0, FSM = IDLE.
- Reset asserted mid-transfer, including during ACK: the ack is dropped the same instant, no strobe is issued, and the register clears.

## Timing
- Hit sampled at edge N. Sl_xferAck, Sl_DBus, the register update and user_data_strb are all registered at edge N+1, valid for one cycle and low again at edge N+2.
- Write latency: OPB_DBus sampled at N appears on user_data_out at N+1.
- user_data_strb coincides with the first cycle the new value is visible.
- No combinational path exists from any OPB input to any output.

## Configuration
- Macro OPB_REG_P2S_READBACK_EN.
- Defined: reads return the register as described under Operation.
- Undefined: the register is write-only. Reads are acked at the same timing, but Sl_DBus stays 0, and the readback mux is not synthesised.
- Write behaviour is identical in both builds.

## Test plan
- Reset: assert OPB_Rst asynchronously mid-cycle -> all outputs 0 immediately, and user_data_out=0 after release.
- Full write: write 0xDEADBEEF with BE=4'b1111 at 0x0108C200 -> xferAck one cycle later, user_data_out=32'hDEADBEEF, one-cycle strb.
- Byte-lane write: from 0xDEADBEEF, write 0x11223344 with BE=4'b0101 -> user_data_out=32'hDE22BE44.
- Readback: read at 0x0108C2FC -> Sl_DBus=0xDE22BE44 only during the ack cycle, 0 otherwise. Without OPB_REG_P2S_READBACK_EN, Sl_DBus=0 with the ack unchanged.
- Address miss: select at 0x0108C300 and at 0x0108C1FC -> no ack, no strobe, register unchanged for 10 cycles.
- Back-to-back and reset mid-ACK:
  - Hold select for two writes, 0x1 then 0x2 -> acks at N+1 and N+3, two strobes, final value 0x2.
  - Assert reset during ACK -> ack drops and register = 0.
